// File: rtl/conv_block_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// conv_block_sequencer_pkg
// Shared definitions for the convolution block sequencer and the address FSM:
// sequencer state encoding, drain sub-phases, default block geometry and the
// block RAM read latency seen by the drain path.
// -----------------------------------------------------------------------------
package conv_block_sequencer_pkg;

  // Default geometry, shared with the address FSM.
  localparam int NB_ADDRESS_DEF = 10;
  localparam int NB_DATA_DEF    = 8;

  // Cycles from an o_valid strobe until the BRAM read data is valid.
  localparam int BRAM_RD_LAT    = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_CB  = 3'd2,
    SOP      = 3'd3,
    RUN      = 3'd4,
    DRAIN    = 3'd5,
    WAIT_CB2 = 3'd6,
    DONE     = 3'd7
  } seq_state_e;

  // Per-word drain steps: request strobe, see strobe, wait read latency,
  // hold result until accepted.
  typedef enum logic [1:0] {
    D_FIRE     = 2'd0,
    D_WAIT_STB = 2'd1,
    D_LAT      = 2'd2,
    D_HOLD     = 2'd3
  } drain_phase_e;

endpackage

// File: rtl/conv_block_sequencer_strober.sv
// -----------------------------------------------------------------------------
// conv_valid_strober
// Turns a one-cycle fire request into a registered one-cycle strobe, issued
// two cycles after the request (one arming cycle lets the data register settle
// before the strobe rises), followed by VALID_GAP low cycles of hold-off.
//
// Ports:
//   clk         in   clock
//   rst_n       in   asynchronous active-low reset
//   fire        in   request a strobe (honoured only while strobe_free)
//   strobe      out  registered one-cycle strobe
//   strobe_free out  no strobe armed, active or in hold-off
// -----------------------------------------------------------------------------
module conv_valid_strober #(
  parameter int VALID_GAP = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic fire,
  output logic strobe,
  output logic strobe_free
);

  localparam int GW = (VALID_GAP > 1) ? $clog2(VALID_GAP) : 1;

  logic          arm_q, arm_d;
  logic          strobe_q, strobe_d;
  logic [GW-1:0] gap_q, gap_d;

  assign strobe_free = !arm_q && !strobe_q && (gap_q == '0);
  assign strobe      = strobe_q;

  always_comb begin
    arm_d    = fire && strobe_free;
    strobe_d = arm_q;
    gap_d    = gap_q;
    // The cycle right after the strobe is the first low cycle, so the
    // counter holds the remaining VALID_GAP-1 hold-off cycles.
    if (strobe_q) begin
      gap_d = GW'(VALID_GAP - 1);
    end else if (gap_q != '0) begin
      gap_d = gap_q - GW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q    <= 1'b0;
      strobe_q <= 1'b0;
      gap_q    <= '0;
    end else begin
      arm_q    <= arm_d;
      strobe_q <= strobe_d;
      gap_q    <= gap_d;
    end
  end

endmodule

// File: rtl/conv_block_sequencer.sv
// -----------------------------------------------------------------------------
// conv_block_sequencer
// Initiator-side controller for the convolution address FSM. Loads one block
// of 2**NB_ADDRESS pixels into BRAM with edge-coded o_valid strobes, waits for
// changeBlock, fires o_SoP, waits for an end-of-process rising edge, then
// drains the result block with the same strobes and a valid/ready handshake.
//
// Optional feature: define CONV_SEQ_WATCHDOG_EN to build a TIMEOUT_CYC-cycle
// watchdog on WAIT_CB, RUN and WAIT_CB2 that sets a sticky o_err and returns
// to IDLE. Without it, o_err is tied low and the wait states may stall.
//
// Ports:
//   i_CLK, i_reset                  clock, asynchronous active-low reset
//   i_start                         begin a load/process/drain cycle (IDLE only)
//   i_pixel, i_pixel_valid          upstream pixel stream
//   o_pixel_ready                   upstream transfer accepted this cycle
//   o_wr_data                       registered pixel to BRAM write port
//   o_valid                         address-step strobe to the FSM
//   o_SoP                           start-of-process pulse
//   i_changeBlock, i_EoP            FSM block-complete / end-of-process
//   i_result                        BRAM read data
//   o_result, o_result_valid        drained word and its valid
//   i_result_ready                  downstream accepts the result
//   o_busy, o_done, o_err           status
// -----------------------------------------------------------------------------
module conv_block_sequencer
  import conv_block_sequencer_pkg::*;
#(
  parameter int NB_ADDRESS  = NB_ADDRESS_DEF,
  parameter int NB_DATA     = NB_DATA_DEF,
  parameter int VALID_GAP   = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               i_CLK,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_pixel,
  input  logic               i_pixel_valid,
  output logic               o_pixel_ready,
  output logic [NB_DATA-1:0] o_wr_data,
  output logic               o_valid,
  output logic               o_SoP,
  input  logic               i_changeBlock,
  input  logic               i_EoP,
  input  logic [NB_DATA-1:0] i_result,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_result_valid,
  input  logic               i_result_ready,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam logic [NB_ADDRESS:0] FULL    = {1'b1, {NB_ADDRESS{1'b0}}};
  localparam logic [NB_ADDRESS:0] FULL_M1 = FULL - 1'b1;

  seq_state_e          state_q, state_d;
  drain_phase_e        dph_q, dph_d;
  logic [NB_ADDRESS:0] wcnt_q, wcnt_d;
  logic [1:0]          lat_q, lat_d;
  logic [NB_DATA-1:0]  wr_data_q, wr_data_d;
  logic [NB_DATA-1:0]  result_q, result_d;
  logic                rvalid_q, rvalid_d;
  logic                sop_q, sop_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                eop_q;

  logic                strobe, strobe_free;
  logic                load_xfer, drain_fire;

`ifdef CONV_SEQ_WATCHDOG_EN
  localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  logic           in_wait;
`endif

  conv_valid_strober #(
    .VALID_GAP (VALID_GAP)
  ) u_strober (
    .clk         (i_CLK),
    .rst_n       (i_reset),
    .fire        (load_xfer || drain_fire),
    .strobe      (strobe),
    .strobe_free (strobe_free)
  );

  // Ready depends only on registered state, so the source sees a stable
  // ready for the whole cycle.
  assign o_pixel_ready  = (state_q == LOAD) && strobe_free && (wcnt_q < FULL);
  assign load_xfer      = o_pixel_ready && i_pixel_valid;

  assign o_valid        = strobe;
  assign o_wr_data      = wr_data_q;
  assign o_SoP          = sop_q;
  assign o_result       = result_q;
  assign o_result_valid = rvalid_q;
  assign o_busy         = busy_q;
  assign o_done         = done_q;

  always_comb begin
    state_d    = state_q;
    dph_d      = dph_q;
    wcnt_d     = wcnt_q;
    lat_d      = lat_q;
    wr_data_d  = wr_data_q;
    result_d   = result_q;
    rvalid_d   = rvalid_q;
    drain_fire = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = LOAD;
          wcnt_d  = '0;
        end
      end
      LOAD: begin
        if (load_xfer) begin
          wr_data_d = i_pixel;
          wcnt_d    = wcnt_q + 1'b1;
        end
        // Leave once the strobe of the final word is on the wire.
        if (strobe && (wcnt_q == FULL)) begin
          state_d = WAIT_CB;
        end
      end
      WAIT_CB: begin
        if (i_changeBlock) begin
          state_d = SOP;
        end
      end
      SOP: begin
        wcnt_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        // Only a fresh rise counts; the FSM keeps EoP high once set.
        if (i_EoP && !eop_q) begin
          state_d = DRAIN;
          dph_d   = D_FIRE;
        end
      end
      DRAIN: begin
        case (dph_q)
          D_FIRE: begin
            if (strobe_free) begin
              drain_fire = 1'b1;
              dph_d      = D_WAIT_STB;
            end
          end
          D_WAIT_STB: begin
            if (strobe) begin
              dph_d = D_LAT;
              lat_d = 2'(BRAM_RD_LAT - 1);
            end
          end
          D_LAT: begin
            if (lat_q == '0) begin
              result_d = i_result;
              rvalid_d = 1'b1;
              dph_d    = D_HOLD;
            end else begin
              lat_d = lat_q - 1'b1;
            end
          end
          D_HOLD: begin
            if (i_result_ready) begin
              rvalid_d = 1'b0;
              wcnt_d   = wcnt_q + 1'b1;
              if (wcnt_q == FULL_M1) begin
                state_d = WAIT_CB2;
              end else begin
                dph_d = D_FIRE;
              end
            end
          end
          default: dph_d = D_FIRE;
        endcase
      end
      WAIT_CB2: begin
        if (i_changeBlock) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef CONV_SEQ_WATCHDOG_EN
    // Counter restarts on every state change; expiry overrides any pending
    // transition and abandons the cycle without o_done.
    in_wait = (state_q == WAIT_CB) || (state_q == RUN) || (state_q == WAIT_CB2);
    err_d   = err_q;
    wd_d    = '0;
    if (in_wait && (wd_q == WDW'(TIMEOUT_CYC - 1))) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end else if (in_wait && (state_d == state_q)) begin
      wd_d = wd_q + 1'b1;
    end
`endif

    sop_d  = (state_d == SOP);
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      dph_q     <= D_FIRE;
      wcnt_q    <= '0;
      lat_q     <= '0;
      wr_data_q <= '0;
      result_q  <= '0;
      rvalid_q  <= 1'b0;
      sop_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      dph_q     <= dph_d;
      wcnt_q    <= wcnt_d;
      lat_q     <= lat_d;
      wr_data_q <= wr_data_d;
      result_q  <= result_d;
      rvalid_q  <= rvalid_d;
      sop_q     <= sop_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      eop_q     <= i_EoP;
    end
  end

`ifdef CONV_SEQ_WATCHDOG_EN
  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_block_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv_block_sequencer
// Scoreboarded bench for conv_block_sequencer with NB_ADDRESS=4 (16-word
// blocks), VALID_GAP=1, TIMEOUT_CYC=32. A monitor on the falling clock edge
// checks load strobes against pushed pixels and drained results against the
// expected BRAM contents, and plays the BRAM read port for the drain.
// -----------------------------------------------------------------------------
module tb_conv_block_sequencer;

  localparam int NA  = 4;
  localparam int ND  = 8;
  localparam int NW  = 16;

  // Result block contents held in the modelled BRAM.
  localparam logic [7:0] RES_TBL [16] = '{
    8'h3C, 8'hA1, 8'h5E, 8'h07, 8'hF2, 8'h99, 8'h10, 8'hC4,
    8'h6B, 8'h2D, 8'hE8, 8'h73, 8'h01, 8'hBE, 8'h48, 8'hD5
  };

  logic          i_CLK = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_start = 1'b0;
  logic [ND-1:0] i_pixel = '0;
  logic          i_pixel_valid = 1'b0;
  logic          o_pixel_ready;
  logic [ND-1:0] o_wr_data;
  logic          o_valid;
  logic          o_SoP;
  logic          i_changeBlock = 1'b0;
  logic          i_EoP = 1'b0;
  logic [ND-1:0] i_result = '0;
  logic [ND-1:0] o_result;
  logic          o_result_valid;
  logic          i_result_ready = 1'b1;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  conv_block_sequencer #(
    .NB_ADDRESS  (NA),
    .NB_DATA     (ND),
    .VALID_GAP   (1),
    .TIMEOUT_CYC (32)
  ) dut (
    .i_CLK          (i_CLK),
    .i_reset        (i_reset),
    .i_start        (i_start),
    .i_pixel        (i_pixel),
    .i_pixel_valid  (i_pixel_valid),
    .o_pixel_ready  (o_pixel_ready),
    .o_wr_data      (o_wr_data),
    .o_valid        (o_valid),
    .o_SoP          (o_SoP),
    .i_changeBlock  (i_changeBlock),
    .i_EoP          (i_EoP),
    .i_result       (i_result),
    .o_result       (o_result),
    .o_result_valid (o_result_valid),
    .i_result_ready (i_result_ready),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_err          (o_err)
  );

  always #5 i_CLK = ~i_CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Scoreboard queues and monitor state.
  logic [7:0] px_q[$];
  logic [7:0] res_q[$];
  bit         in_load  = 1'b0;
  bit         in_drain = 1'b0;
  int         strobe_cnt = 0;
  int         res_acc = 0;
  int         sop_cycles = 0;
  int         done_cycles = 0;
  int         rd_idx = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] wr_prev = '0;

  always @(negedge i_CLK) begin
    logic [7:0] e;
    if (!in_drain) rd_idx = 0;
    if (o_valid) check("valid_gap", {31'd0, prev_valid}, 32'd0);
    if (o_valid && !prev_valid) begin
      strobe_cnt++;
      if (in_load) begin
        if (px_q.size() > 0) e = px_q.pop_front();
        else e = 8'hxx;
        // Data must already have been stable on the previous cycle.
        check("load_data", {16'd0, wr_prev, o_wr_data}, {16'd0, e, e});
      end
      if (in_drain) begin
        i_result = RES_TBL[rd_idx % NW];
        rd_idx++;
      end
    end
    if (o_result_valid && i_result_ready) begin
      if (res_q.size() > 0) e = res_q.pop_front();
      else e = 8'hxx;
      check("result", {24'd0, o_result}, {24'd0, e});
      res_acc++;
    end
    if (o_SoP) sop_cycles++;
    if (o_done) done_cycles++;
    prev_valid = o_valid;
    wr_prev    = o_wr_data;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_CLK);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
  endtask

  task automatic pulse_cb();
    i_changeBlock = 1'b1;
    tick(1);
    i_changeBlock = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ready"},  {31'd0, o_pixel_ready},  32'd0);
    check({name, "_valid"},  {31'd0, o_valid},        32'd0);
    check({name, "_wrdata"}, {24'd0, o_wr_data},      32'd0);
    check({name, "_sop"},    {31'd0, o_SoP},          32'd0);
    check({name, "_result"}, {24'd0, o_result},       32'd0);
    check({name, "_rvalid"}, {31'd0, o_result_valid}, 32'd0);
    check({name, "_busy"},   {31'd0, o_busy},         32'd0);
    check({name, "_done"},   {31'd0, o_done},         32'd0);
    check({name, "_err"},    {31'd0, o_err},          32'd0);
  endtask

  // Offer pixels 0..n_words-1; optionally withhold valid before word stall_at.
  task automatic load_words(input int n_words, input int stall_at);
    int s0;
    bit ok;
    for (int k = 0; k < n_words; k++) begin
      if (k == stall_at) begin
        i_pixel_valid = 1'b0;
        tick(3);
        s0 = strobe_cnt;
        tick(5);
        check("stall_no_strobe", strobe_cnt - s0, 0);
      end
      i_pixel       = 8'(k);
      i_pixel_valid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge i_CLK);
        if (o_pixel_ready) begin
          px_q.push_back(8'(k));
          ok = 1'b1;
          break;
        end
      end
      check("pixel_accept", {31'd0, ok}, 32'd1);
      if (!ok) break;
      @(posedge i_CLK);
      #1;
    end
    i_pixel_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int target);
    for (int c = 0; c < 200 && strobe_cnt < target; c++) @(negedge i_CLK);
  endtask

  task automatic run_cycle(input int stall_at, input int bp_word, input bit start_in_run);
    int base_s, base_sop, base_done, base_res, s_drain, s_bp;
    logic [7:0] held;
    base_s    = strobe_cnt;
    base_sop  = sop_cycles;
    base_done = done_cycles;
    base_res  = res_acc;

    in_load = 1'b1;
    pulse_start();
    check("busy_after_start", {31'd0, o_busy}, 32'd1);
    load_words(NW, stall_at);
    wait_strobes(base_s + NW);
    tick(4);
    in_load = 1'b0;
    check("load_strobes", strobe_cnt - base_s, NW);
    check("ready_in_wait_cb", {31'd0, o_pixel_ready}, 32'd0);
    check("busy_in_wait_cb", {31'd0, o_busy}, 32'd1);
    check("no_sop_before_cb", sop_cycles - base_sop, 0);

    pulse_cb();
    tick(3);
    check("sop_pulse", sop_cycles - base_sop, 1);

    if (start_in_run) begin
      pulse_start();
      tick(1);
      check("busy_start_in_run", {31'd0, o_busy}, 32'd1);
      check("no_strobe_in_run", strobe_cnt - base_s, NW);
    end

    for (int j = 0; j < NW; j++) res_q.push_back(RES_TBL[j]);
    in_drain = 1'b1;
    s_drain  = strobe_cnt;
    i_EoP    = 1'b1;

    if (bp_word >= 0) begin
      for (int c = 0; c < 500 && (res_acc - base_res) < bp_word; c++) @(negedge i_CLK);
      @(posedge i_CLK);
      #1;
      i_result_ready = 1'b0;
      for (int c = 0; c < 100 && !o_result_valid; c++) @(negedge i_CLK);
      check("bp_word_valid", {31'd0, o_result_valid}, 32'd1);
      held = o_result;
      s_bp = strobe_cnt;
      repeat (3) begin
        @(negedge i_CLK);
        check("bp_hold_data", {24'd0, o_result}, {24'd0, held});
        check("bp_hold_valid", {31'd0, o_result_valid}, 32'd1);
      end
      check("bp_no_strobe", strobe_cnt - s_bp, 0);
      @(posedge i_CLK);
      #1;
      i_result_ready = 1'b1;
    end

    for (int c = 0; c < 2000 && (res_acc - base_res) < NW; c++) @(negedge i_CLK);
    tick(4);
    check("drain_results", res_acc - base_res, NW);
    check("drain_strobes", strobe_cnt - s_drain, NW);
    check("result_queue_empty", res_q.size(), 0);
    check("busy_in_wait_cb2", {31'd0, o_busy}, 32'd1);
    check("no_done_before_cb", done_cycles - base_done, 0);
    in_drain = 1'b0;

    pulse_cb();
    tick(3);
    i_EoP = 1'b0;
    check("done_pulse", done_cycles - base_done, 1);
    check("busy_after_done", {31'd0, o_busy}, 32'd0);
    check("err_clear", {31'd0, o_err}, 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int base_done;

    // Reset state.
    tick(2);
    check_all_zero("reset");
    i_reset = 1'b1;
    tick(2);
    check_all_zero("post_reset_idle");

    // Plain full cycle.
    run_cycle(-1, -1, 1'b0);

    // Upstream stall at word 5, backpressure on word 7, start during RUN.
    run_cycle(5, 7, 1'b1);

    // Asynchronous reset in the middle of LOAD, at word 9.
    in_load = 1'b1;
    pulse_start();
    load_words(9, -1);
    i_pixel       = 8'd9;
    i_pixel_valid = 1'b1;
    @(negedge i_CLK);
    #2;
    i_reset = 1'b0;
    #1;
    check_all_zero("async_reset");
    i_pixel_valid = 1'b0;
    tick(2);
    px_q.delete();
    in_load = 1'b0;
    i_reset = 1'b1;
    tick(2);

    // Restart begins cleanly at word 0.
    run_cycle(-1, -1, 1'b0);

    // changeBlock withheld after a load.
    base_done = done_cycles;
    in_load = 1'b1;
    pulse_start();
    load_words(NW, -1);
    wait_strobes(strobe_cnt + 2);
    tick(4);
    in_load = 1'b0;
    tick(40);
`ifdef CONV_SEQ_WATCHDOG_EN
    check("wd_err_set", {31'd0, o_err}, 32'd1);
    check("wd_idle", {31'd0, o_busy}, 32'd0);
    check("wd_no_done", done_cycles - base_done, 0);
    tick(5);
    check("wd_err_sticky", {31'd0, o_err}, 32'd1);
`else
    check("nowd_err_low", {31'd0, o_err}, 32'd0);
    check("nowd_still_busy", {31'd0, o_busy}, 32'd1);
    check("nowd_no_ready", {31'd0, o_pixel_ready}, 32'd0);
    check("nowd_no_done", done_cycles - base_done, 0);
`endif
    i_reset = 1'b0;
    tick(2);
    check_all_zero("final_reset");
    i_reset = 1'b1;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
